// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase-shift sequencer.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        WAIT_LOCK,
        DONE
    } state_e;

    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Command handshake bundle for the phase-shift sequencer.
interface pll_phase_ctrl_if #(
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_sel;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;

    modport master (
        output cmd_valid, cmd_sel, cmd_dir, cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_dir, cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/pll_phase_timer.sv
// Loadable down-counter shared by every timed sequencer state.
module pll_phase_timer #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL phase-step sequencer; position tracking built only when
// PLL_PHASE_TRACK_EN is defined.
import pll_phase_pkg::*;

module pll_phase_ctrl #(
    parameter int STEP_W       = 8,
    parameter int POS_W        = 8,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    pll_phase_ctrl_if.slave  cmd,
    input  logic             pll_lock,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [1:0]       pos_sel,
    output logic [POS_W-1:0] phase_pos
);
    localparam int TMAX = max4(SETUP_CYC, PULSE_CYC, GAP_CYC, LOCK_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    state_e            state_q, state_d;
    logic [1:0]        sel_q;
    logic              dir_q;
    logic [STEP_W-1:0] rem_q;
    logic              lost_q;
    logic              err_q;
    logic              step_q;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_exp;
    logic          accept;
    logic          step_fire;
    logic          timeout;

    pll_phase_timer #(.W(TW)) u_timer (
        .clk_i    (clk_25mhz),
        .rst_i    (rst),
        .load_i   (tmr_load),
        .val_i    (tmr_val),
        .expire_o (tmr_exp)
    );

    assign cmd.cmd_ready = (state_q == IDLE) && !rst;

    // Each timed state lasts (loaded value + 1) cycles.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        accept    = 1'b0;
        step_fire = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    accept = 1'b1;
                    if (cmd.cmd_steps == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (tmr_exp) begin
                    state_d  = PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                if (tmr_exp) begin
                    state_d   = GAP;
                    step_fire = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (rem_q != '0) begin
                        state_d = PULSE;
                        tmr_val = TW'(PULSE_CYC - 1);
                    end else begin
                        state_d = WAIT_LOCK;
                        tmr_val = TW'(LOCK_TIMEOUT - 1);
                    end
                end
            end
            WAIT_LOCK: begin
                if (pll_lock) begin
                    state_d = DONE;
                end else if (tmr_exp) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_CLKOP;
            dir_q   <= DIR_INC;
            rem_q   <= '0;
            lost_q  <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= (state_d == PULSE);
            if (accept) begin
                sel_q  <= cmd.cmd_sel;
                dir_q  <= cmd.cmd_dir;
                rem_q  <= cmd.cmd_steps;
                lost_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (step_fire) begin
                rem_q <= rem_q - 1'b1;
            end
            if ((state_q == PULSE || state_q == GAP) && !pll_lock) begin
                lost_q <= 1'b1;
            end
            if (state_q == WAIT_LOCK && state_d == DONE) begin
                err_q <= lost_q | timeout;
            end
        end
    end

    assign phasesel  = sel_q;
    assign phasedir  = dir_q;
    assign phasestep = step_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

`ifdef PLL_PHASE_TRACK_EN
    logic [POS_W-1:0] pos_q [4];

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= '0;
            end
        end else if (step_fire) begin
            if (dir_q == DIR_DEC) begin
                pos_q[sel_q] <= pos_q[sel_q] - 1'b1;
            end else begin
                pos_q[sel_q] <= pos_q[sel_q] + 1'b1;
            end
        end
    end

    assign phase_pos = pos_q[pos_sel];
`else
    logic unused_pos_sel;
    assign unused_pos_sel = ^pos_sel;
    assign phase_pos      = '0;
`endif
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with hand-computed pulse/done timing.
`timescale 1ns/1ps
module tb_pll_phase_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] pos_sel;
    logic [7:0] phase_pos;

    int n_run  = 0;
    int n_fail = 0;

    pll_phase_ctrl_if #(.STEP_W(8)) cmd_if ();

    pll_phase_ctrl dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .cmd       (cmd_if.slave),
        .pll_lock  (pll_lock),
        .phasesel  (phasesel),
        .phasedir  (phasedir),
        .phasestep (phasestep),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pos_sel   (pos_sel),
        .phase_pos (phase_pos)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ep(input logic [7:0] v);
`ifdef PLL_PHASE_TRACK_EN
        return v;
`else
        return (v & 8'h00);
`endif
    endfunction

    task automatic rd_pos(input logic [1:0] s, output logic [7:0] p);
        pos_sel = s;
        #1;
        p = phase_pos;
    endtask

    // Cycle n of a run is the n-th cycle after the accept cycle.
    task automatic run_cmd(
        input  logic [1:0]  s,
        input  logic        d,
        input  logic [7:0]  st,
        input  int          lo_from,
        input  int          lo_to,
        input  bit          hold,
        output int          done_at,
        output logic [63:0] ps_tr,
        output logic [63:0] rd_tr,
        output logic        er,
        output logic        hold_ok,
        output logic [7:0]  p7
    );
        int w;
        w = 0;
        while (!cmd_if.cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        cmd_if.cmd_sel   = s;
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_steps = st;
        cmd_if.cmd_valid = 1'b1;
        ps_tr   = '0;
        rd_tr   = '0;
        done_at = -1;
        er      = 1'b0;
        hold_ok = 1'b1;
        p7      = 8'hxx;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (!hold) cmd_if.cmd_valid = 1'b0;
            #1;
            if (n < 64) begin
                ps_tr[n] = phasestep;
                rd_tr[n] = cmd_if.cmd_ready;
            end
            if (n == 7) p7 = phase_pos;
            if (phasesel !== s || phasedir !== d) hold_ok = 1'b0;
            pll_lock = !(n >= lo_from && n < lo_to);
            if (done) begin
                done_at = n;
                er      = err;
                break;
            end
        end
        pll_lock = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          da;
        logic [63:0] ps;
        logic [63:0] rd;
        logic        er;
        logic        ok;
        logic [7:0]  p7;
        logic [7:0]  p;

        rst              = 1'b1;
        pll_lock         = 1'b1;
        pos_sel          = 2'd0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_sel   = 2'd1;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = 8'd1;

        repeat (4) @(negedge clk);
        chk("rst_ready", cmd_if.cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {phasestep, phasesel, phasedir, done, err}, 0);
        rd_pos(2'd1, p);
        chk("rst_pos", p, 0);
        rst              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        #1;
        chk("rel_ready", cmd_if.cmd_ready, 1);
        @(negedge clk);
        chk("rel_idle", busy, 0);

        pos_sel = 2'd1;
        run_cmd(2'd1, 1'b0, 8'd1, 999, 999, 0, da, ps, rd, er, ok, p7);
        chk("s1_done_at", da, 16);
        chk("s1_pulse", ps, 64'h78);
        chk("s1_ready", rd, 0);
        chk("s1_sel_hold", ok, 1);
        chk("s1_err", er, 0);
        rd_pos(2'd1, p);
        chk("s1_pos1", p, ep(8'd1));

        pos_sel = 2'd2;
        run_cmd(2'd2, 1'b1, 8'd3, 999, 999, 0, da, ps, rd, er, ok, p7);
        chk("m3_done_at", da, 40);
        chk("m3_pulse", ps, 64'h7807_8078);
        chk("m3_pos_first", p7, ep(8'd255));
        chk("m3_sel_hold", ok, 1);
        chk("m3_err", er, 0);
        rd_pos(2'd2, p);
        chk("m3_pos_end", p, ep(8'd253));

        run_cmd(2'd3, 1'b0, 8'd2, 15, 19, 0, da, ps, rd, er, ok, p7);
        chk("ll_done_at", da, 28);
        chk("ll_pulse", ps, 64'h7_8078);
        chk("ll_err", er, 1);
        rd_pos(2'd3, p);
        chk("ll_pos3", p, ep(8'd2));

        run_cmd(2'd0, 1'b0, 8'd1, 15, 100000, 0, da, ps, rd, er, ok, p7);
        chk("to_done_at", da, 1039);
        chk("to_err", er, 1);

        run_cmd(2'd1, 1'b0, 8'd0, 999, 999, 0, da, ps, rd, er, ok, p7);
        chk("z_done_at", da, 1);
        chk("z_pulse", ps, 0);
        chk("z_err", er, 0);
        rd_pos(2'd1, p);
        chk("z_pos1", p, ep(8'd1));

        run_cmd(2'd1, 1'b1, 8'd1, 999, 999, 1, da, ps, rd, er, ok, p7);
        chk("bp_done_at", da, 16);
        chk("bp_ready", rd, 0);
        rd_pos(2'd1, p);
        chk("bp_pos1_a", p, ep(8'd0));
        @(negedge clk);
        #1;
        chk("bp_ready_back", cmd_if.cmd_ready, 1);
        @(negedge clk);
        #1;
        chk("bp_second_acc", busy, 1);
        cmd_if.cmd_valid = 1'b0;
        da = -1;
        for (int n = 2; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                da = n;
                break;
            end
        end
        chk("bp2_done_at", da, 16);
        @(negedge clk);
        rd_pos(2'd1, p);
        chk("bp_pos1_b", p, ep(8'd255));

        while (!cmd_if.cmd_ready) @(negedge clk);
        cmd_if.cmd_sel   = 2'd2;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = 8'd5;
        cmd_if.cmd_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            cmd_if.cmd_valid = 1'b0;
        end
        chk("rm_pulse_on", phasestep, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_step_off", phasestep, 0);
        chk("rm_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            rd_pos(2'(i), p);
            chk($sformatf("rm_pos%0d", i), p, 0);
        end
        rst = 1'b0;
        #1;
        chk("rm_ready", cmd_if.cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Sequencer for the ECP5 EHXPLLL dynamic phase-shift port. It accepts phase-step commands over a valid/ready handshake and drives the PLL's PHASESEL, PHASEDIR and PHASESTEP inputs with fixed setup, pulse and gap timing. After the last step it waits for PLL lock and reports completion or timeout. It runs on the stable 25 MHz reference clock, next to the PLL wrapper, and lets a host or test logic tune the output clock phase at run time.

## Interface
Parameters:
- STEP_W, 8: width of the step-count field.
- POS_W, 8: width of each tracked phase-position counter.
- SETUP_CYC, 2: cycles PHASESEL/PHASEDIR are held stable before the first pulse.
- PULSE_CYC, 4: PHASESTEP high time in cycles.
- GAP_CYC, 8: PHASESTEP low time after each pulse.
- LOCK_TIMEOUT, 1024: maximum cycles spent waiting for lock.

Ports:
- clk_25mhz  in  1  sole clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_sel  in  2  output select: 0 CLKOP, 1 CLKOS, 2 CLKOS2, 3 CLKOS3.
- cmd_dir  in  1  direction: 0 increments position, 1 decrements.
- cmd_steps  in  STEP_W  number of PHASESTEP pulses to issue.
- pll_lock  in  1  PLL LOCK output, already synchronous to clk_25mhz.
- phasesel  out  2  to PLL PHASESEL1:0.
- phasedir  out  1  to PLL PHASEDIR.
- phasestep  out  1  to PLL PHASESTEP.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  status of the last command; valid while done is high, and held until the next accept.
- pos_sel  in  2  selects which output's position to read.
- phase_pos  out  POS_W  tracked phase position of output pos_sel.

## Operation
- FSM states: IDLE, SETUP, PULSE, GAP, WAIT_LOCK, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept (cmd_valid & cmd_ready), latch sel/dir/steps into phasesel/phasedir and the remaining-step counter, clear err and the lock-lost flag, then go to SETUP.
  - If cmd_steps=0, go directly to DONE with err=0 and emit no pulses.
- SETUP: hold for SETUP_CYC cycles, then go to PULSE.
- PULSE: phasestep=1 for PULSE_CYC cycles, then go to GAP.
- GAP:
  - At GAP entry, decrement the remaining count and update the position of the latched output: +1 if dir=0, −1 if dir=1, wrapping modulo 2^POS_W.
  - Hold for GAP_CYC cycles. If the remaining count is nonzero, go to PULSE (no repeated SETUP); otherwise go to WAIT_LOCK.
- WAIT_LOCK:
  - If pll_lock=1, go to DONE.
  - If LOCK_TIMEOUT cycles elapse first, go to DONE with err=1.
- DONE: done=1 for one cycle, then go to IDLE.
- Lock loss: if pll_lock is observed low in PULSE or GAP, set a sticky lock_lost flag. The sequence still completes. At DONE, err = timeout OR lock_lost.
- phasesel and phasedir must not change from accept until DONE.
- busy=1 in every state except IDLE. cmd_ready=0 whenever busy=1.
- phase_pos is a combinational read of position register [pos_sel].

## Timing
- Reset values: cmd_ready=0 while rst=1, and 1 in the first cycle after rst falls. phasestep, phasesel, phasedir, busy, done and err are all 0. All positions are 0.
- All PLL-facing outputs are registered and glitch-free.
- Accept at cycle T with N≥1 steps and lock held high:
  - SETUP occupies T+1..T+SETUP_CYC.
  - Pulse k (k=0..N−1) is high for PULSE_CYC cycles starting at T+SETUP_CYC+1+k·(PULSE_CYC+GAP_CYC).
  - WAIT_LOCK takes one cycle.
  - done rises at T+SETUP_CYC+N·(PULSE_CYC+GAP_CYC)+2. With defaults and N=1, done is at T+16.
- Zero-step command: done at T+1.
- cmd_ready returns to 1 in the cycle after done.
- Reset mid-operation: phasestep drops in the next cycle, the FSM returns to IDLE, and positions clear to 0. A partial pulse is acceptable.

## Configuration
- PLL_PHASE_TRACK_EN defined: the four POS_W position registers and the phase_pos readback are built.
- PLL_PHASE_TRACK_EN undefined: no position registers are built, phase_pos is tied to 0, and pos_sel is ignored. All other behaviour is identical.

## Structure
- Package pll_phase_pkg holds:
  - the state enum;
  - the PHASESEL encodings (SEL_CLKOP=0, SEL_CLKOS=1, SEL_CLKOS2=2, SEL_CLKOS3=3);
  - the direction constants DIR_INC=0, DIR_DEC=1.
- Sub-module pll_phase_timer: a loadable down-counter sized for max(SETUP_CYC, PULSE_CYC, GAP_CYC, LOCK_TIMEOUT) with an expire output. It is shared by all timed states.

## Test plan
- Reset release:
  - Expect all outputs 0 during rst and cmd_ready=1 one cycle after release.
  - A command offered during rst is not accepted.
- Single step, defaults, lock high: sel=1, dir=0, steps=1 accepted at T.
  - phasestep is high exactly on T+3..T+6, phasesel=1 throughout.
  - done at T+16, err=0, phase_pos[1]=1.
- Multi-step decrement: steps=3, dir=1 from position 0.
  - Expect three 4-cycle pulses spaced 12 cycles apart.
  - phase_pos=255 after the first step, 253 at completion.
- Lock handling:
  - Drop pll_lock during the second pulse and restore it at GAP: err=1 at done.
  - Hold pll_lock low through WAIT_LOCK: done arrives after LOCK_TIMEOUT cycles with err=1.
- Zero steps and backpressure:
  - steps=0: done at T+1, no phasestep.
  - cmd_valid held high during busy: no second accept until the cycle after done.
- Reset at T+5 of a 5-step command: phasestep=0 and busy=0 by T+6, all positions 0.
